// File: rtl/dma_tx_pkg.sv
// Shared definitions for the DMA TX staging FIFO and its drain stage.
package dma_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } drain_st_t;

    localparam int FIFO_AW = 11;
    localparam int BEAT_W  = 512;

endpackage

// File: rtl/dma_tx_fifo_drain.sv
// Drains 1024-bit FIFO entries as 512-bit valid/ready beats framed by packet lengths,
// and reports FIFO level, almost-full and packet completion status.
module dma_tx_fifo_drain
    import dma_tx_pkg::*;
#(
    parameter int AFULL_TH = 1984,
    parameter int LEN_W    = 16
) (
    input  logic                user_clk,
    input  logic                reset,
    input  logic [FIFO_AW-1:0]  fifo_wp,
    input  logic [FIFO_AW-1:0]  fifo_rp,
    input  logic [BEAT_W-1:0]   fifo_rd1,
    input  logic [BEAT_W-1:0]   fifo_rd2,
    output logic                fifo_re,
    input  logic                len_valid,
    input  logic [LEN_W-1:0]    len,
    output logic                len_ready,
    output logic [BEAT_W-1:0]   m_data,
    output logic                m_valid,
    output logic                m_last,
    input  logic                m_ready,
    output logic [FIFO_AW:0]    fifo_level,
    output logic                fifo_afull,
    output logic                pkt_done,
    output logic [31:0]         pkt_cnt
);

    drain_st_t         state;
    logic [LEN_W-1:0]  beats_left;
    logic              head_ok;
    logic              accept;

    // Pointers never differ by a full 2048, so equality always means empty.
    assign head_ok    = (fifo_wp != fifo_rp);
    assign fifo_level = {1'b0, fifo_wp - fifo_rp};

    // Beat presentation: low half in LO, high half in HI, nothing offered in IDLE.
    always_comb begin
        m_data    = fifo_rd1;
        m_valid   = 1'b0;
        len_ready = 1'b0;
        case (state)
            IDLE: begin
                len_ready = 1'b1;
            end
            LO: begin
                m_valid = head_ok;
            end
            HI: begin
                m_data  = fifo_rd2;
                m_valid = head_ok;
            end
            default: begin
                m_valid   = 1'b0;
                len_ready = 1'b0;
            end
        endcase
    end

    // A last beat in LO also pops, discarding the unused high half of odd packets.
    assign m_last  = m_valid & (beats_left == LEN_W'(1));
    assign accept  = m_valid & m_ready;
    assign fifo_re = accept & ((state == HI) | m_last);

    // Framing FSM, packet status and registered almost-full flag.
    always_ff @(posedge user_clk) begin
        if (reset) begin
            state      <= IDLE;
            beats_left <= '0;
            pkt_done   <= 1'b0;
            pkt_cnt    <= 32'd0;
            fifo_afull <= 1'b0;
        end else begin
            pkt_done   <= accept & m_last;
            pkt_cnt    <= pkt_cnt + {31'd0, accept & m_last};
            fifo_afull <= (fifo_level >= (FIFO_AW+1)'(AFULL_TH));
            case (state)
                IDLE: begin
                    if (len_valid) begin
                        // A zero length is coerced to one beat so the FSM always returns.
                        beats_left <= (len == '0) ? LEN_W'(1) : len;
                        state      <= LO;
                    end else begin
                        state <= IDLE;
                    end
                end
                LO: begin
                    if (accept) begin
                        beats_left <= beats_left - LEN_W'(1);
                        state      <= m_last ? IDLE : HI;
                    end else begin
                        state <= LO;
                    end
                end
                HI: begin
                    if (accept) begin
                        beats_left <= beats_left - LEN_W'(1);
                        state      <= m_last ? IDLE : LO;
                    end else begin
                        state <= HI;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_tx_fifo_drain.sv
// Scoreboard bench for dma_tx_fifo_drain with a behavioural staging FIFO model.
module tb_dma_tx_fifo_drain;

    logic          user_clk = 1'b0;
    logic          reset;
    logic [10:0]   fifo_wp, fifo_rp;
    logic [511:0]  fifo_rd1, fifo_rd2;
    logic          fifo_re;
    logic          len_valid;
    logic [15:0]   len;
    logic          len_ready;
    logic [511:0]  m_data;
    logic          m_valid, m_last, m_ready;
    logic [11:0]   fifo_level;
    logic          fifo_afull, pkt_done;
    logic [31:0]   pkt_cnt;

    typedef struct packed {
        logic [511:0] d;
        logic         last;
        logic         re;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          next_entry = 0;
    int          exp_cnt = 0;

    logic [31:0] wr_total, rd_total, wr_target;
    int          wr_gap, gap_cnt;
    logic        ovr;
    logic [10:0] ovr_wp, ovr_rp;

    always #5 user_clk = ~user_clk;

    dma_tx_fifo_drain #(.AFULL_TH(10), .LEN_W(16)) dut (
        .user_clk(user_clk), .reset(reset),
        .fifo_wp(fifo_wp), .fifo_rp(fifo_rp),
        .fifo_rd1(fifo_rd1), .fifo_rd2(fifo_rd2), .fifo_re(fifo_re),
        .len_valid(len_valid), .len(len), .len_ready(len_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .fifo_level(fifo_level), .fifo_afull(fifo_afull),
        .pkt_done(pkt_done), .pkt_cnt(pkt_cnt)
    );

    function automatic logic [511:0] gen_lo(input logic [31:0] k);
        return {16{k ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [511:0] gen_hi(input logic [31:0] k);
        return {16{~k}};
    endfunction

    // Entry k's content is a pure function of k, so the head follows the read count.
    assign fifo_rd1 = gen_lo(rd_total);
    assign fifo_rd2 = gen_hi(rd_total);
    assign fifo_wp  = ovr ? ovr_wp : wr_total[10:0];
    assign fifo_rp  = ovr ? ovr_rp : rd_total[10:0];

    // Staging FIFO model: pops on fifo_re, writes one entry every wr_gap+1 cycles up to wr_target.
    always @(posedge user_clk) begin
        if (reset) begin
            wr_total <= 32'd0;
            rd_total <= 32'd0;
            gap_cnt  <= 0;
        end else begin
            if (fifo_re) rd_total <= rd_total + 32'd1;
            if (wr_total != wr_target) begin
                if (gap_cnt == 0) begin
                    wr_total <= wr_total + 32'd1;
                    gap_cnt  <= wr_gap;
                end else begin
                    gap_cnt <= gap_cnt - 1;
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge user_clk);
        reset = 1'b1; len_valid = 1'b0; m_ready = 1'b0; ovr = 1'b0;
        wr_target = 32'd0; wr_gap = 0;
        repeat (2) @(negedge user_clk);
        reset = 1'b0;
        q.delete();
        next_entry = 0;
        exp_cnt = 0;
    endtask

    task automatic run_packet(input int plen, input int pct, input bit fill, output int stall_seen);
        exp_t        e;
        int          eff, guard;
        bit          prev_stall;
        logic [511:0] prev_data;
        eff = (plen == 0) ? 1 : plen;
        stall_seen = 0;
        for (int i = 0; i < eff; i++) begin
            e.d    = (i % 2 == 1) ? gen_hi(32'(next_entry + i / 2)) : gen_lo(32'(next_entry + i / 2));
            e.last = (i == eff - 1);
            e.re   = (i % 2 == 1) || (i == eff - 1);
            q.push_back(e);
        end
        next_entry += (eff + 1) / 2;
        @(negedge user_clk);
        if (fill) wr_target = wr_target + 32'((eff + 1) / 2);
        len = 16'(plen);
        len_valid = 1'b1;
        #1;
        checks++;
        if (len_ready !== 1'b1) begin
            errors++; $display("FAIL len_ready_idle: got %b want 1", len_ready);
        end
        prev_stall = 1'b0;
        prev_data  = '0;
        guard = 0;
        while (q.size() > 0 && guard < 5000) begin
            @(negedge user_clk);
            len_valid = 1'b0;
            m_ready = ($urandom_range(0, 99) < pct);
            #1;
            guard++;
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    errors++; $display("FAIL stall_stable: valid %b data_eq %b want valid 1 data_eq 1",
                                       m_valid, m_data == prev_data);
                end
            end
            if (m_valid !== 1'b1) begin
                stall_seen++;
                checks++;
                if (fifo_re !== 1'b0) begin
                    errors++; $display("FAIL re_while_invalid: got %b want 0", fifo_re);
                end
            end else begin
                e = q[0];
                checks++;
                if (m_data !== e.d || m_last !== e.last) begin
                    errors++; $display("FAIL beat: data %h last %b want data %h last %b",
                                       m_data[31:0], m_last, e.d[31:0], e.last);
                end
                checks++;
                if (fifo_re !== (m_ready & e.re)) begin
                    errors++; $display("FAIL fifo_re: got %b want %b", fifo_re, m_ready & e.re);
                end
                if (m_ready) void'(q.pop_front());
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
        if (q.size() > 0) begin
            errors++; $display("FAIL packet_timeout: %0d beats outstanding, want 0", q.size());
            q.delete();
        end
        @(negedge user_clk);
        m_ready = 1'b0;
        #1;
        exp_cnt++;
        checks++;
        if (pkt_done !== 1'b1 || pkt_cnt !== 32'(exp_cnt)) begin
            errors++; $display("FAIL pkt_done_cnt: done %b cnt %0d want done 1 cnt %0d",
                               pkt_done, pkt_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (len_ready !== 1'b1 || m_valid !== 1'b0 || m_last !== 1'b0 || fifo_re !== 1'b0 ||
            pkt_done !== 1'b0 || pkt_cnt !== 32'd0 || fifo_afull !== 1'b0 || fifo_level !== 12'd0) begin
            errors++; $display("FAIL reset_state: rdy %b val %b last %b re %b done %b cnt %0d af %b lvl %0d",
                               len_ready, m_valid, m_last, fifo_re, pkt_done, pkt_cnt, fifo_afull, fifo_level);
        end
    endtask

    task automatic test_even_packet();
        int st;
        wr_target = 32'd4;
        repeat (6) @(negedge user_clk);
        run_packet(4, 100, 1'b0, st);
        checks++;
        if (rd_total !== 32'd2) begin
            errors++; $display("FAIL even_pops: got %0d want 2", rd_total);
        end
    endtask

    task automatic test_odd_packet();
        int st;
        run_packet(3, 100, 1'b0, st);
        checks++;
        if (rd_total !== 32'd4) begin
            errors++; $display("FAIL odd_pops: got %0d want 4", rd_total);
        end
        run_packet(2, 100, 1'b1, st);
    endtask

    task automatic test_empty_fifo();
        int st;
        wr_gap = 2;
        run_packet(8, 100, 1'b1, st);
        checks++;
        if (st == 0) begin
            errors++; $display("FAIL empty_stall: invalid cycles %0d want >0", st);
        end
        wr_gap = 0;
    endtask

    task automatic test_len_zero();
        int st;
        run_packet(0, 100, 1'b1, st);
        run_packet(1, 100, 1'b1, st);
    endtask

    task automatic test_level();
        @(negedge user_clk);
        ovr = 1'b1; ovr_wp = 11'd5; ovr_rp = 11'd2040;
        #1;
        checks++;
        if (fifo_level !== 12'd13 || fifo_afull !== 1'b0) begin
            errors++; $display("FAIL level_wrap13: lvl %0d af %b want 13 0", fifo_level, fifo_afull);
        end
        @(negedge user_clk);
        #1;
        checks++;
        if (fifo_afull !== 1'b1) begin
            errors++; $display("FAIL afull_rise: got %b want 1", fifo_afull);
        end
        ovr_wp = 11'd3; ovr_rp = 11'd2045;
        #1;
        checks++;
        if (fifo_level !== 12'd6 || fifo_afull !== 1'b1) begin
            errors++; $display("FAIL level_wrap6: lvl %0d af %b want 6 1", fifo_level, fifo_afull);
        end
        @(negedge user_clk);
        ovr_wp = 11'd10; ovr_rp = 11'd0;
        #1;
        checks++;
        if (fifo_level !== 12'd10 || fifo_afull !== 1'b0) begin
            errors++; $display("FAIL afull_fall: lvl %0d af %b want 10 0", fifo_level, fifo_afull);
        end
        @(negedge user_clk);
        #1;
        checks++;
        if (fifo_afull !== 1'b1) begin
            errors++; $display("FAIL afull_at_th: got %b want 1", fifo_afull);
        end
        ovr = 1'b0;
        @(negedge user_clk);
        #1;
        checks++;
        if (fifo_afull !== 1'b0 || fifo_level !== 12'd0) begin
            errors++; $display("FAIL afull_clear: af %b lvl %0d want 0 0", fifo_afull, fifo_level);
        end
    endtask

    task automatic test_back_to_back();
        int st;
        apply_reset();
        for (int p = 0; p < 100; p++) begin
            run_packet($urandom_range(1, 64), 50, 1'b1, st);
        end
        checks++;
        if (pkt_cnt !== 32'd100) begin
            errors++; $display("FAIL pkt_cnt_100: got %0d want 100", pkt_cnt);
        end
    endtask

    task automatic test_reset_mid_packet();
        int accepted, guard;
        apply_reset();
        wr_target = 32'd3;
        repeat (5) @(negedge user_clk);
        len = 16'd6;
        len_valid = 1'b1;
        m_ready = 1'b1;
        accepted = 0;
        guard = 0;
        while (accepted < 2 && guard < 100) begin
            @(negedge user_clk);
            len_valid = 1'b0;
            #1;
            guard++;
            if (m_valid === 1'b1) accepted++;
        end
        checks++;
        if (accepted != 2) begin
            errors++; $display("FAIL mid_reset_setup: accepted %0d want 2", accepted);
        end
        @(negedge user_clk);
        reset = 1'b1;
        wr_target = 32'd0;
        #1;
        checks++;
        if (m_valid !== 1'b1 || pkt_cnt !== 32'd0 + 32'd0) begin
            errors++; $display("FAIL beat3_offered: valid %b want 1", m_valid);
        end
        @(negedge user_clk);
        #1;
        checks++;
        if (len_ready !== 1'b1 || m_valid !== 1'b0 || m_last !== 1'b0 || pkt_cnt !== 32'd0) begin
            errors++; $display("FAIL mid_reset: rdy %b val %b last %b cnt %0d want 1 0 0 0",
                               len_ready, m_valid, m_last, pkt_cnt);
        end
        reset = 1'b0;
        m_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; len_valid = 1'b0; len = 16'd0; m_ready = 1'b0;
        ovr = 1'b0; ovr_wp = 11'd0; ovr_rp = 11'd0;
        wr_target = 32'd0; wr_gap = 0;
        test_reset();
        test_even_packet();
        test_odd_packet();
        test_empty_fifo();
        test_len_zero();
        test_level();
        test_back_to_back();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_tx_fifo_drain.md
# dma_tx_fifo_drain

Drain stage directly downstream of the DMA TX staging FIFO. Pops 1024-bit FIFO entries, each held as two 512-bit halves, and emits them as a 512-bit valid/ready beat stream framed by per-packet beat counts from a length queue. It derives FIFO occupancy from the FIFO's write and read pointers, generates the FIFO pop strobe, and reports packet and level status to the TX controller.

## Interface
Parameters:
- AFULL_TH, default 1984: level at or above which `fifo_afull` asserts (entries).
- LEN_W, default 16: width of the packet length field, in 64-byte beats.

Ports:
- `user_clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `fifo_wp`  in  11  FIFO write pointer (entries).
- `fifo_rp`  in  11  FIFO read pointer (entries).
- `fifo_rd1`  in  512  head entry, low half (beat 0).
- `fifo_rd2`  in  512  head entry, high half (beat 1).
- `fifo_re`  out  1  pop the head entry; one-cycle pulse per entry.
- `len_valid`  in  1  packet length available.
- `len`  in  LEN_W  packet length in beats; 0 is illegal.
- `len_ready`  out  1  length accepted this cycle.
- `m_data`  out  512  output beat.
- `m_valid`  out  1  beat valid.
- `m_last`  out  1  final beat of the packet.
- `m_ready`  in  1  downstream accepts the beat.
- `fifo_level`  out  12  (fifo_wp − fifo_rp) mod 2048, zero-extended.
- `fifo_afull`  out  1  `fifo_level` ≥ AFULL_TH, registered.
- `pkt_done`  out  1  one-cycle pulse when an `m_last` beat is accepted.
- `pkt_cnt`  out  32  count of completed packets; wraps.

## Operation
- Head valid: `head_ok = (fifo_wp != fifo_rp)`. Upstream keeps occupancy ≤ 2047, so `fifo_wp == fifo_rp` always means empty.
- The FIFO updates the head registers in the same cycle its pointers advance. When `head_ok` is true, `fifo_rd1` and `fifo_rd2` are current.
- FSM states:
  - IDLE: `len_ready` = 1. On `len_valid`, load `beats_left = len` and go to LO.
  - LO: `m_data = fifo_rd1`. `m_valid = head_ok`.
  - HI: `m_data = fifo_rd2`. `m_valid = head_ok`.
- `m_last = m_valid & (beats_left == 1)`.
- Beat accepted (`m_valid & m_ready`) in LO:
  - If not last, go to HI.
  - If last, pulse `fifo_re` (odd-length packet; `fifo_rd2` is discarded) and go to IDLE.
- Beat accepted in HI: always pulse `fifo_re`. If last, go to IDLE; otherwise go to LO.
- Every accepted beat decrements `beats_left`.
- An entry never straddles two packets. Each packet starts at the low half of a fresh entry.
- `len` = 0 is a protocol error. Treat it as 1 so the FSM cannot hang; no flag is raised.
- `pkt_done` and `pkt_cnt` increment on acceptance of an `m_last` beat.

## Timing
- Reset values:
  - State IDLE, `beats_left` = 0, `pkt_cnt` = 0.
  - `fifo_re`, `pkt_done`, `fifo_afull` = 0.
  - `len_ready` = 1 (IDLE).
  - `m_valid`, `m_last` = 0.
  - `m_data` = `fifo_rd1`, which is don't-care while `m_valid` is 0.
- `m_valid`, `m_data`, `m_last` and `fifo_re` are combinational from the FSM state and the registered inputs. There is no added latency.
- `fifo_re` is asserted in the same cycle as the accepting handshake. The next head is visible in the following cycle.
- Back-to-back entries stream with no bubble while `head_ok` holds. `m_valid` drops for any cycle in which the FIFO is empty.
- `m_valid` does not depend on `m_ready`. Once asserted, `m_valid` and `m_data` stay stable until accepted: the head does not change without `fifo_re`.
- Length-to-first-beat: `len` is accepted at cycle N. The first beat is offered at N+1 if `head_ok`. There is one idle cycle between packets.
- `fifo_level` is combinational. `fifo_afull` lags it by one cycle.
- Pointer wrap: the subtraction is 11-bit modulo, so wp = 3, rp = 2045 gives level 6.
- `reset` mid-packet: the FSM returns to IDLE and the residual beat count is dropped. FIFO pointers belong to the FIFO, which must be reset in the same cycle.

## Structure
- Shared package `dma_tx_pkg`:
  - `typedef enum logic [1:0] {IDLE, LO, HI} drain_st_t`.
  - `localparam FIFO_AW = 11` and `localparam BEAT_W = 512`, used by both the FIFO and this block.
- Single module with no sub-modules. The level/afull logic is small enough to stay inline.

## Test plan
- Length 4, four entries preloaded, `m_ready` = 1 → 4 beats `rd1`, `rd2`, `rd1`, `rd2`; `m_last` on beat 4; 2 `fifo_re` pulses; `pkt_cnt` = 1.
- Length 3, two entries → 3 beats; `fifo_re` on beats 2 and 3; second entry's `rd2` never emitted; next packet starts on `rd1` of entry 3.
- Length 8, FIFO empty, one entry written every 3 cycles → `m_valid` low while empty, no `fifo_re` while empty, 8 beats delivered in order.
- Random `m_ready` at 50% over 100 packets of lengths 1–64 → `m_data` matches the scoreboard, `m_valid` and `m_data` stable while stalled, `pkt_cnt` = 100.
- `fifo_wp` = 5, `fifo_rp` = 2040 → `fifo_level` = 13. With AFULL_TH = 10, `fifo_afull` rises one cycle later.
- `reset` asserted on beat 3 of a length-6 packet → next cycle IDLE, `len_ready` = 1, `m_valid` = 0, `pkt_cnt` = 0.
